// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one RAM port between IF fetch and MEM load/store
// MEM has priority; a starvation counter forces an IF grant after MAX_WAIT MEM wins.
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  output logic          stall_if,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic          mem_gnt,
  output logic          mem_valid,
  output logic [DW-1:0] mem_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  input  logic          ram_ready,
  output logic          sel
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          first_q;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;
  logic          mem_win, if_win, done;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_win = 1'b0;
    if_win  = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        // IF only beats a pending MEM request once the counter has saturated
        mem_win = mem_req && (!if_req || (cnt_q < CNT_MAX));
        if_win  = if_req && !mem_win;
        if (mem_win) begin
          state_d = BUSY_MEM;
          if (if_req) cnt_d = cnt_q + CW'(1);
        end else if (if_win) begin
          state_d = BUSY_IF;
          cnt_d   = '0;
        end
      end
      BUSY_IF, BUSY_MEM: begin
        if (ram_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      if_valid  <= 1'b0;
      mem_valid <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      first_q   <= mem_win || if_win;
      if (mem_win) begin
        addr_q  <= mem_addr;
        we_q    <= mem_we;
        wdata_q <= mem_wdata;
      end else if (if_win) begin
        addr_q  <= if_addr;
      end
      if_valid  <= done && (state_q == BUSY_IF);
      mem_valid <= done && (state_q == BUSY_MEM);
      if (done && (state_q == BUSY_IF))  if_rdata  <= ram_rdata;
      if (done && (state_q == BUSY_MEM)) mem_rdata <= ram_rdata;
    end
  end

  assign if_gnt    = first_q && (state_q == BUSY_IF);
  assign mem_gnt   = first_q && (state_q == BUSY_MEM);
  assign ram_en    = (state_q != IDLE);
  assign ram_we    = (state_q == BUSY_MEM) && we_q;
  assign sel       = (state_q == BUSY_MEM);
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  // rst_n gating keeps stall_if low during reset even if if_req is already up
  assign stall_if  = rst_n && ((if_req && !if_gnt && (state_q != BUSY_IF)) || (state_q == BUSY_IF));

endmodule
